// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair: shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to make MULT/MULTU single-cycle; the divide path is the same either way.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rega_i,
  input  logic [WIDTH-1:0] regb_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, CALC = 2'd2, FIX = 2'd3} state_t;

  localparam logic [2:0]       OP_MULT   = 3'd0;
  localparam logic [2:0]       OP_MULTU  = 3'd1;
  localparam logic [2:0]       OP_DIVU   = 3'd3;
  localparam logic [2:0]       OP_MTHI   = 3'd4;
  localparam logic [2:0]       OP_MTLO   = 3'd5;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     opa, opb, addend;
  logic [2*WIDTH-1:0]   acc, acc_nxt, prod_fix;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div, is_signed, neg_res, neg_rem, div_zero;
  logic                 req, cap, start_iter, fix_wr;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b, quo_fix, rem_fix, hi_fix, lo_fix;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;

  // Cancel outranks start, including in IDLE.
  assign req    = start_i && !cancel_i && (state == IDLE);
  assign cap    = req && (op_i <= OP_DIVU);
  assign fix_wr = (state == FIX) && !cancel_i;
  assign busy_o = (state != IDLE);

`ifdef MULDIV_FAST_MUL_EN
  logic               fm_pend, fm_wr;
  logic [2*WIDTH-1:0] fm_prod;

  assign start_iter = cap && op_i[1];
  assign fm_wr      = fm_pend && !cancel_i;
  // Sign-extended operands: the low 2*WIDTH bits of the product are right for both signednesses.
  assign fm_prod    = {{WIDTH{a_neg}}, opa} * {{WIDTH{b_neg}}, opb};

  // One-cycle flag between accepting a fast multiply and writing its product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fm_pend <= 1'b0;
    end else begin
      fm_pend <= cap && ((op_i == OP_MULT) || (op_i == OP_MULTU));
    end
  end
`else
  assign start_iter = cap;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_iter) state_nxt = PREP;
        else            state_nxt = IDLE;
      end
      PREP: begin
        if (cancel_i) state_nxt = IDLE;
        else          state_nxt = CALC;
      end
      CALC: begin
        if (cancel_i)               state_nxt = IDLE;
        else if (cnt == LAST_STEP)  state_nxt = FIX;
        else                        state_nxt = CALC;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitudes, one radix-2 step, and the sign-corrected results
  always_comb begin
    a_neg     = is_signed & opa[WIDTH-1];
    b_neg     = is_signed & opb[WIDTH-1];
    mag_a     = a_neg ? -opa : opa;
    mag_b     = b_neg ? -opb : opb;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : {(WIDTH+1){1'b0}});
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, addend};
    if (!is_div) begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      hi_fix = opa;
      lo_fix = {WIDTH{1'b1}};
    end else begin
      hi_fix = rem_fix;
      lo_fix = quo_fix;
    end
  end

  // Operand capture and iterative datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa       <= {WIDTH{1'b0}};
      opb       <= {WIDTH{1'b0}};
      addend    <= {WIDTH{1'b0}};
      acc       <= {(2*WIDTH){1'b0}};
      cnt       <= {CNT_W{1'b0}};
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      if (cap) begin
        opa       <= rega_i;
        opb       <= regb_i;
        is_div    <= op_i[1];
        is_signed <= ~op_i[0];
      end
      case (state)
        PREP: begin
          cnt      <= {CNT_W{1'b0}};
          neg_res  <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          div_zero <= is_div && (opb == {WIDTH{1'b0}});
          // Divide shifts the dividend through acc; multiply shifts the multiplier.
          if (is_div) begin
            acc    <= {{WIDTH{1'b0}}, mag_a};
            addend <= mag_b;
          end else begin
            acc    <= {{WIDTH{1'b0}}, mag_b};
            addend <= mag_a;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        default: cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  // HI/LO, divide-by-zero flag and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_o   <= {WIDTH{1'b0}};
      lo_o   <= {WIDTH{1'b0}};
      dz_o   <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (fix_wr) begin
        hi_o   <= hi_fix;
        lo_o   <= lo_fix;
        dz_o   <= div_zero;
        done_o <= 1'b1;
      end
`ifdef MULDIV_FAST_MUL_EN
      if (fm_wr) begin
        hi_o   <= fm_prod[2*WIDTH-1:WIDTH];
        lo_o   <= fm_prod[WIDTH-1:0];
        done_o <= 1'b1;
      end
`endif
      if (req && (op_i == OP_MTHI)) hi_o <= rega_i;
      if (req && (op_i == OP_MTLO)) lo_o <= rega_i;
      if (cap) dz_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start_i, cancel_i;
  logic [2:0]    op_i;
  logic [W-1:0]  rega_i, regb_i;
  logic          busy_o, done_o, dz_o;
  logic [W-1:0]  hi_o, lo_o;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rega_i(rega_i), .regb_i(regb_i),
    .cancel_i(cancel_i), .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op);
    return (FAST && op <= 3'd1) ? 1 : W + 2;
  endfunction

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % takes the dividend sign.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = 32'd0; l = 32'd0; dz = 1'b0;
    case (op)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 32'd0; l = a; end
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; dz = 1'b1; end
        else begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; rega_i = a; regb_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Edges after the start edge until done_o is seen; 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 100 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done_o) lat = i;
    end
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz);
    int lat;
    issue(op, a, b);
    chk({name, "_busy"}, busy_o, !(FAST && op <= 3'd1));
    wait_done(lat);
    chk({name, "_latency"}, lat, exp_lat(op));
    chk({name, "_hi"}, hi_o, eh);
    chk({name, "_lo"}, lo_o, el);
    chk({name, "_dz"}, dz_o, edz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    logic [31:0] mh, ml, a, b, th, tl;
    logic        mdz, tdz;
    logic [2:0]  op;

    rst = 1'b0; start_i = 1'b0; cancel_i = 1'b0; op_i = 3'd0; rega_i = 32'd0; regb_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_dz", dz_o, 1'b0);

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[5] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[7] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    // Each issue lands in the done cycle of the previous one (back-to-back acceptance).
    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

    run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(3'd4, 32'h1234, 32'd0);
    chk("mthi_hi", hi_o, 32'h1234);
    chk("mthi_lo", lo_o, 32'hFFFF_FFF1);
    chk("mthi_done", done_o, 1'b0);
    chk("mthi_busy", busy_o, 1'b0);
    issue(3'd5, 32'hABCD, 32'd0);
    chk("mtlo_lo", lo_o, 32'hABCD);
    issue(3'd6, 32'h5555_5555, 32'd1);
    chk("op6_hi", hi_o, 32'h1234);
    chk("op6_busy", busy_o, 1'b0);
    count_done(3, seen);
    chk("op6_no_done", seen, 0);

    // Cancel during the divide: no write, no done.
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); cancel_i = 1'b1;
    @(posedge clk); #1; cancel_i = 1'b0;
    chk("cancel_busy", busy_o, 1'b0);
    count_done(40, seen);
    chk("cancel_no_done", seen, 0);
    chk("cancel_hi", hi_o, 32'h1234);
    chk("cancel_lo", lo_o, 32'hABCD);

    @(negedge clk); start_i = 1'b1; cancel_i = 1'b1; op_i = 3'd3; rega_i = 32'd100; regb_i = 32'd7;
    @(posedge clk); #1; start_i = 1'b0; cancel_i = 1'b0;
    chk("cancel_start_busy", busy_o, 1'b0);

    // A start while busy is dropped, not queued.
    issue(3'd3, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk); start_i = 1'b1; op_i = 3'd3; rega_i = 32'd9; regb_i = 32'd1;
    @(posedge clk); #1; start_i = 1'b0;
    wait_done(lat);
    chk("midstart_latency", lat + 6, W + 2);
    chk("midstart_hi", hi_o, 32'd2);
    chk("midstart_lo", lo_o, 32'd14);
    count_done(40, seen);
    chk("midstart_no_second_done", seen, 0);

    // Reset in the middle of a divide.
    run_op("divu_5_0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_dz", dz_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_done(40, seen);
    chk("midrst_no_done", seen, 0);

    mh = 32'd0; ml = 32'd0; mdz = 1'b0;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
        4: b = 32'($urandom_range(1, 1000));
        default: ;
      endcase
      if (op <= 3'd3) begin
        model(op, a, b, mh, ml, mdz);
        run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, mh, ml, mdz);
        @(posedge clk); #1;
        chk($sformatf("rnd%0d_done_pulse", n), done_o, 1'b0);
      end else begin
        if (op == 3'd4) mh = a;
        if (op == 3'd5) ml = a;
        issue(op, a, b);
        chk($sformatf("rnd%0d_hi", n), hi_o, mh);
        chk($sformatf("rnd%0d_lo", n), lo_o, ml);
        chk($sformatf("rnd%0d_busy", n), busy_o, 1'b0);
        chk($sformatf("rnd%0d_done", n), done_o, 1'b0);
      end
    end
    model(3'd6, 32'd0, 32'd0, th, tl, tdz);
    chk("model_idle_op", {th, tl}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
